// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/gnt/rvalid handshake,
// store lane steering, load alignment/extension and pipeline stall.
// Params : ADDR_W (byte-address width), TIMEOUT (REQ/RESP abort limit, 0 = off)
// Ports  : clk, rst_n (async, active-high), memread_mem, memwrite_mem,
//          funct3_mem, alu_result_mem, store_data_mem -> data_mem,
//          stall_mem, bus_err_mem; dmem_req/we/addr/be/wdata <-> dmem_gnt,
//          dmem_rvalid, dmem_rdata.
// Option : `define MEM_MISALIGN_TRAP_EN adds misalign_exc and traps
//          misaligned accesses instead of forcing alignment.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              memread_mem,
   input  logic              memwrite_mem,
   input  logic [2:0]        funct3_mem,
   input  logic [31:0]       alu_result_mem,
   input  logic [31:0]       store_data_mem,
   output logic [31:0]       data_mem,
   output logic              stall_mem,
   output logic              bus_err_mem,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_exc
`endif
);

   localparam bit TO_EN = (TIMEOUT > 0);
   localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [31:0]       wd_q;
   logic              berr_q;

   logic        access;
   logic        start;
   logic        is_b;
   logic        is_h;
   logic [1:0]  off;
   logic [1:0]  off_al;
   logic [3:0]  be_d;
   logic [31:0] wd_d;
   logic        to_hit;
   logic        abort;
   logic        load_done;
   logic        busy;
   logic [31:0] sh;
   logic [31:0] ext;

   assign access = memread_mem | memwrite_mem;
   assign off    = alu_result_mem[1:0];
   assign is_b   = (funct3_mem[1:0] == 2'b00);
   assign is_h   = (funct3_mem[1:0] == 2'b01);

   // Lane decode; the latched offset is the naturally aligned one so
   // misaligned halves/words collapse onto their containing lanes.
   always_comb begin
      off_al = 2'b00;
      be_d   = 4'b1111;
      wd_d   = store_data_mem;
      unique case (1'b1)
         is_b: begin
            off_al = off;
            be_d   = 4'b0001 << off;
            wd_d   = {4{store_data_mem[7:0]}};
         end
         is_h: begin
            off_al = {off[1], 1'b0};
            be_d   = off[1] ? 4'b1100 : 4'b0011;
            wd_d   = {2{store_data_mem[15:0]}};
         end
         default: begin
            off_al = 2'b00;
            be_d   = 4'b1111;
            wd_d   = store_data_mem;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = (is_h & off[0]) |
                     (funct3_mem[1] & (off != 2'b00));
   assign start = access & ~misalign;
   assign misalign_exc = ~rst_n & (state_q == IDLE) &
                         access & misalign;
`else
   assign start = access;
`endif

   // Abort fires on the TIMEOUT-th cycle spent in REQ or RESP.
   assign to_hit = TO_EN && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      abort     = 1'b0;
      load_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = REQ;
         end
         REQ: begin
            if (dmem_gnt) begin
               state_d = we_q ? DONE : RESP;
            end else if (to_hit) begin
               state_d = DONE;
               abort   = 1'b1;
            end
         end
         RESP: begin
            if (dmem_rvalid) begin
               state_d   = DONE;
               load_done = 1'b1;
            end else if (to_hit) begin
               state_d = DONE;
               abort   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         addr_q <= '0;
         f3_q   <= '0;
         we_q   <= 1'b0;
         be_q   <= '0;
         wd_q   <= '0;
      end else if ((state_q == IDLE) && start) begin
         addr_q <= {alu_result_mem[ADDR_W-1:2], off_al};
         f3_q   <= funct3_mem;
         we_q   <= memwrite_mem;
         be_q   <= be_d;
         wd_q   <= wd_d;
      end
   end

   assign sh = dmem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      ext = sh;
      case (f3_q)
         3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
         3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
         3'b100:  ext = {24'd0, sh[7:0]};
         3'b101:  ext = {16'd0, sh[15:0]};
         default: ext = sh;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         data_mem <= '0;
         berr_q   <= 1'b0;
      end else begin
         berr_q <= abort;
         if (load_done) begin
            data_mem <= ext;
         end else if (abort) begin
            data_mem <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         end else if (misalign_exc) begin
            data_mem <= '0;
`endif
         end
      end
   end

   assign busy        = (state_q == REQ) | (state_q == RESP);
   assign stall_mem   = ~rst_n &
                        (busy | ((state_q == IDLE) & start));
   assign bus_err_mem = berr_q;
   assign dmem_req    = (state_q == REQ);
   assign dmem_we     = dmem_req & we_q;
   assign dmem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
   assign dmem_be     = be_q;
   assign dmem_wdata  = wd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, wait states,
// timeout abort, async reset mid-transaction and misalignment handling.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memread_mem;
   logic        memwrite_mem;
   logic [2:0]  funct3_mem;
   logic [31:0] alu_result_mem;
   logic [31:0] store_data_mem;
   logic [31:0] data_mem;
   logic        stall_mem;
   logic        bus_err_mem;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_exc;
`endif

   int errs = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_W (32),
      .TIMEOUT(8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .memread_mem   (memread_mem),
      .memwrite_mem  (memwrite_mem),
      .funct3_mem    (funct3_mem),
      .alu_result_mem(alu_result_mem),
      .store_data_mem(store_data_mem),
      .data_mem      (data_mem),
      .stall_mem     (stall_mem),
      .bus_err_mem   (bus_err_mem),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_be       (dmem_be),
      .dmem_wdata    (dmem_wdata),
      .dmem_gnt      (dmem_gnt),
      .dmem_rvalid   (dmem_rvalid),
      .dmem_rdata    (dmem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_exc  (misalign_exc)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access from the IDLE cycle through DONE; gnt after gd
   // request cycles, rvalid one cycle after gnt for loads.
   task automatic run(input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input int gd,
                      input logic [31:0] rdat,
                      output int stalls,
                      output logic [31:0] q_addr,
                      output logic [3:0] q_be,
                      output logic [31:0] q_wd,
                      output logic q_we,
                      output logic stable,
                      output logic [31:0] q_data,
                      output int berrs,
                      output logic hung);
      int   nreq;
      logic pend;
      memread_mem    = rd;
      memwrite_mem   = wr;
      funct3_mem     = f3;
      alu_result_mem = a;
      store_data_mem = sd;
      dmem_gnt       = 1'b0;
      dmem_rvalid    = 1'b0;
      stalls = 0;
      nreq   = 0;
      pend   = 1'b0;
      stable = 1'b1;
      berrs  = 0;
      hung   = 1'b1;
      q_addr = '0;
      q_be   = '0;
      q_wd   = '0;
      q_we   = 1'b0;
      q_data = '0;
      for (int c = 0; c < 40; c++) begin
         if (pend) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdat;
            pend        = 1'b0;
         end
         #1;
         if (bus_err_mem) berrs++;
         if (!stall_mem) begin
            hung   = 1'b0;
            q_data = data_mem;
            break;
         end
         stalls++;
         if (dmem_req) begin
            if (nreq == 0) begin
               q_addr = dmem_addr;
               q_be   = dmem_be;
               q_wd   = dmem_wdata;
               q_we   = dmem_we;
            end else if (dmem_addr !== q_addr || dmem_be !== q_be ||
                         dmem_wdata !== q_wd || dmem_we !== q_we) begin
               stable = 1'b0;
            end
            if (nreq >= gd) begin
               dmem_gnt = 1'b1;
               pend     = ~dmem_we;
            end
            nreq++;
         end
         @(posedge clk);
         #1;
         dmem_gnt    = 1'b0;
         dmem_rvalid = 1'b0;
      end
      memread_mem  = 1'b0;
      memwrite_mem = 1'b0;
      @(posedge clk);
      #1;
      if (bus_err_mem) berrs++;
   endtask

   int          st;
   logic [31:0] qa;
   logic [3:0]  qb;
   logic [31:0] qw;
   logic        qe;
   logic        stb;
   logic [31:0] qd;
   int          be_n;
   logic        hg;

   initial begin
      rst_n          = 1'b1;
      memread_mem    = 1'b0;
      memwrite_mem   = 1'b0;
      funct3_mem     = 3'b000;
      alu_result_mem = '0;
      store_data_mem = '0;
      dmem_gnt       = 1'b0;
      dmem_rvalid    = 1'b0;
      dmem_rdata     = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_data", data_mem, 32'h0);
      chk("rst_stall", {31'd0, stall_mem}, 32'h0);
      chk("rst_req", {31'd0, dmem_req}, 32'h0);
      chk("rst_berr", {31'd0, bus_err_mem}, 32'h0);
      chk("rst_be", {28'd0, dmem_be}, 32'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      // LB 0x103: top byte 0x80 sign-extends
      run(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_1234,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("lb_hung", {31'd0, hg}, 32'h0);
      chk("lb_stall", st, 32'd3);
      chk("lb_addr", qa, 32'h100);
      chk("lb_be", {28'd0, qb}, 32'h8);
      chk("lb_we", {31'd0, qe}, 32'h0);
      chk("lb_data", qd, 32'hFFFF_FF80);

      // SH 0x202: upper half lanes, data_mem untouched
      run(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 0,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("sh_stall", st, 32'd2);
      chk("sh_addr", qa, 32'h200);
      chk("sh_be", {28'd0, qb}, 32'hC);
      chk("sh_wdata", qw, 32'hABCD_ABCD);
      chk("sh_we", {31'd0, qe}, 32'h1);
      chk("sh_hold", qd, 32'hFFFF_FF80);

      // LHU 0x2 with four wait cycles before gnt
      run(1, 0, 3'b101, 32'h2, 0, 4, 32'h9876_5432,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("lhu_stable", {31'd0, stb}, 32'h1);
      chk("lhu_stall", st, 32'd7);
      chk("lhu_addr", qa, 32'h0);
      chk("lhu_be", {28'd0, qb}, 32'h3 << 2);
      chk("lhu_data", qd, 32'h0000_9876);

      // SB 0x1: byte replicated, lane 1
      run(0, 1, 3'b000, 32'h1, 32'h1234_565A, 0, 0,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("sb_be", {28'd0, qb}, 32'h2);
      chk("sb_wdata", qw, 32'h5A5A_5A5A);

      // LB 0x0 positive, LBU 0x1 zero-extended
      run(1, 0, 3'b000, 32'h0, 0, 0, 32'h1234_567F,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("lb0_data", qd, 32'h0000_007F);
      run(1, 0, 3'b100, 32'h1, 0, 0, 32'h0000_8000,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("lbu_data", qd, 32'h0000_0080);

`ifdef MEM_MISALIGN_TRAP_EN
      // LW 0x6 trapped: no request, no stall, data cleared
      memread_mem    = 1'b1;
      funct3_mem     = 3'b010;
      alu_result_mem = 32'h6;
      #1;
      chk("trap_exc", {31'd0, misalign_exc}, 32'h1);
      chk("trap_stall", {31'd0, stall_mem}, 32'h0);
      chk("trap_req", {31'd0, dmem_req}, 32'h0);
      @(posedge clk);
      #1;
      memread_mem = 1'b0;
      #1;
      chk("trap_data", data_mem, 32'h0);
      chk("trap_exc_off", {31'd0, misalign_exc}, 32'h0);
      chk("trap_req2", {31'd0, dmem_req}, 32'h0);
      @(posedge clk);
      #1;
`else
      // Misaligned LW/LH forced to natural alignment
      run(1, 0, 3'b010, 32'h6, 0, 0, 32'h1122_3344,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("mlw_addr", qa, 32'h4);
      chk("mlw_be", {28'd0, qb}, 32'hF);
      chk("mlw_data", qd, 32'h1122_3344);
      run(1, 0, 3'b001, 32'h3, 0, 0, 32'h8001_0000,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("mlh_be", {28'd0, qb}, 32'hC);
      chk("mlh_data", qd, 32'hFFFF_8001);
`endif

      run(1, 0, 3'b010, 32'h10, 0, 0, 32'hDEAD_BEEF,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("lw_data", qd, 32'hDEAD_BEEF);

      // No gnt ever: abort after 8 REQ cycles
      run(1, 0, 3'b010, 32'h40, 0, 1000, 0,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("to_hung", {31'd0, hg}, 32'h0);
      chk("to_stall", st, 32'd9);
      chk("to_data", qd, 32'h0);
      chk("to_berr", be_n, 32'd1);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      chk("to_late_rv", data_mem, 32'h0);

      // Reset while waiting for rvalid
      run(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_1234,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("lb2_data", qd, 32'hFFFF_FF80);
      memread_mem    = 1'b1;
      funct3_mem     = 3'b010;
      alu_result_mem = 32'h20;
      @(posedge clk);
      #1;
      dmem_gnt = 1'b1;
      @(posedge clk);
      #1;
      dmem_gnt = 1'b0;
      #1;
      chk("resp_stall", {31'd0, stall_mem}, 32'h1);
      rst_n = 1'b1;
      #1;
      chk("mrst_req", {31'd0, dmem_req}, 32'h0);
      chk("mrst_stall", {31'd0, stall_mem}, 32'h0);
      chk("mrst_data", data_mem, 32'h0);
      @(posedge clk);
      #1;
      memread_mem = 1'b0;
      rst_n       = 1'b0;
      @(posedge clk);
      #1;
      chk("post_req", {31'd0, dmem_req}, 32'h0);
      run(1, 0, 3'b010, 32'h10, 0, 0, 32'hDEAD_BEEF,
          st, qa, qb, qw, qe, stb, qd, be_n, hg);
      chk("rec_stall", st, 32'd3);
      chk("rec_data", qd, 32'hDEAD_BEEF);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM load/store request and runs a req/gnt/rvalid handshake with the data memory.
- Aligns and extends load data; drives data_mem into MEM/WB.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, data-memory byte-address width (taken from alu_result_mem[ADDR_W-1:0]).
- TIMEOUT, 255, max cycles in REQ or RESP before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock, posedge.
- rst_n  in  1  reset: asynchronous, active-high (asserted = 1).
- memread_mem  in  1  load in MEM.
- memwrite_mem  in  1  store in MEM.
- funct3_mem  in  3  RISC-V width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result_mem  in  32  byte address.
- store_data_mem  in  32  rs2 value (unshifted).
- data_mem  out  32  aligned, extended load result to MEM/WB.
- stall_mem  out  1  holds PC/IF/ID/EX/MEM registers.
- bus_err_mem  out  1  one-cycle pulse on timeout abort.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid (loads only).
- dmem_rdata  in  32  read word.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; timeout counter = 0. Reset mid-transaction abandons it; dmem_req drops asynchronously.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - memread_mem|memwrite_mem → latch addr, funct3, we, be, shifted wdata; go to REQ; stall_mem=1 combinationally this cycle.
  - Both memread_mem and memwrite_mem high → treated as store.
- REQ:
  - dmem_req=1; outputs held stable until gnt.
  - gnt & we → DONE.
  - gnt & !we → RESP.
- RESP:
  - dmem_req=0; wait dmem_rvalid.
  - On rvalid: rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, W unmodified; register into data_mem; go to DONE.
- DONE:
  - stall_mem=0 for exactly one cycle so MEM/WB captures and EX/MEM advances; go to IDLE.
  - Next cycle IDLE evaluates the new instruction; back-to-back accesses allowed.
- stall_mem = 1 in IDLE-with-access, REQ and RESP; 0 otherwise.
- Latency: gnt same cycle as req and rvalid next cycle → load stalls 3 cycles (data_mem valid in DONE); store stalls 2 cycles.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<{addr[1],1'b0}.
  - W: 1111.
- wdata: byte/half replicated across lanes.
- data_mem holds its last value outside DONE; stores leave it unchanged.
- Timeout (TIMEOUT>0):
  - Counter increments in REQ/RESP and clears on state change.
  - Reaching TIMEOUT → bus_err_mem=1 for one cycle; go to DONE; data_mem=0.
  - rvalid arriving after abort is ignored.
- Misaligned access (H with addr[0]=1; W with addr[1:0]!=0), macro absent: low bits forced to alignment (H clears bit0, W clears bits1:0).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_exc (1 bit).
  - Misaligned access in IDLE issues no bus request and no stall.
  - misalign_exc pulses 1 for that cycle; data_mem forced to 0 at next edge.
  - FSM stays in IDLE.
- Undefined: port absent; alignment forcing as in Behaviour.

Test Plan:
- Reset mid-RESP: assert rst_n=1 while waiting rvalid → dmem_req=0, stall_mem=0, data_mem=0, state IDLE.
- LB addr 0x103, rdata=0x80FF_1234, gnt immediate, rvalid +1 → dmem_addr=0x100, be=1000, data_mem=0xFFFF_FF80, stall_mem high 3 cycles.
- SH addr 0x202, store_data=0x0000_ABCD → be=1100, wdata=0xABCD_ABCD, dmem_we=1, completes after gnt, stall_mem high 2 cycles.
- LHU addr 0x2, gnt delayed 4 cycles → dmem_req/addr/be stable all 4 cycles, data_mem=zero-extended upper half.
- TIMEOUT=8, gnt never asserted → bus_err_mem pulses once after 8 REQ cycles, data_mem=0, pipeline released.
- MEM_MISALIGN_TRAP_EN defined, LW addr 0x6 → no dmem_req, misalign_exc=1 one cycle, stall_mem=0.
